// File: rtl/conv_param_pkg.sv
// ---------------------------------------------------------------------------
// conv_param_pkg
//
// Shared definitions for the convolution parameter memories. Holds the
// loader FSM state encoding, the fixed 3x3 tap count, and the default
// filter count, data width and RAM address widths. These defaults match
// the memory map the time-multiplexed convolution engine expects.
// ---------------------------------------------------------------------------
package conv_param_pkg;

   // 3x3 kernel, stored row-major p00..p22
   localparam int TAPS            = 9;
   localparam int TAP_WIDTH       = $clog2(TAPS);

   // Memory-map defaults shared with the convolution engine
   localparam int DEF_NUM_FILTERS = 32;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_WADDR_WIDTH = 15;
   localparam int DEF_BADDR_WIDTH = 6;

   // CHECK is only entered when the checksum option is built in
   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_B,
      CHECK,
      DONE
   } load_state_t;

endpackage

// File: rtl/conv_param_loader.sv
// ---------------------------------------------------------------------------
// conv_param_loader
//
// Streaming writer for the conv weight RAM (3x3 taps per filter) and the
// per-filter bias RAM. Bytes arrive over a valid/ready handshake in the
// order w0..w8, bias, for each filter in turn. Every accepted byte is
// written one cycle later with registered address and data. The loader
// never reads either RAM.
//
// Optional feature, enabled by the macro LOADER_CHECKSUM_EN:
//   One trailing byte follows the last bias. chk_err is set when that byte
//   differs from the 8-bit modular sum of all weight and bias bytes.
//   Without the macro, chk_err is tied low.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             one-cycle pulse, starts a load from IDLE or DONE
//   s_valid, s_data   source byte stream
//   s_ready           loader can accept a byte this cycle
//   w_wren/addr/data  weight RAM write port
//   b_wren/addr/data  bias RAM write port
//   busy              load in progress
//   done              load complete, held until the next start
//   chk_err           checksum mismatch (checksum build only)
// ---------------------------------------------------------------------------
module conv_param_loader
   import conv_param_pkg::*;
#(
   parameter int NUM_FILTERS = DEF_NUM_FILTERS,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
   parameter int BADDR_WIDTH = DEF_BADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   s_valid,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic                   s_ready,
   output logic                   w_wren,
   output logic [WADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0]  w_data,
   output logic                   b_wren,
   output logic [BADDR_WIDTH-1:0] b_addr,
   output logic [DATA_WIDTH-1:0]  b_data,
   output logic                   busy,
   output logic                   done,
   output logic                   chk_err
);

   load_state_t            state;
   load_state_t            state_next;
   logic [TAP_WIDTH-1:0]   tap_cnt;
   logic [BADDR_WIDTH-1:0] filter_cnt;
   logic [WADDR_WIDTH-1:0] waddr_cnt;
   logic                   accept;
   logic                   load_start;
   logic                   last_tap;
   logic                   last_filter;

   assign accept      = s_valid && s_ready;
   assign load_start  = start && ((state == IDLE) || (state == DONE));
   assign last_tap    = (tap_cnt == TAP_WIDTH'(TAPS - 1));
   assign last_filter = (filter_cnt == BADDR_WIDTH'(NUM_FILTERS - 1));

   // State register. Reset drops straight back to IDLE, even mid-load.
   // The host is expected to reload after a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode. s_valid is used directly here rather
   // than accept, so s_ready never feeds back into its own block. A start
   // pulse is only honoured from IDLE or DONE, so a start while loading
   // has no effect.
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = LOAD_W;
         end
         LOAD_W: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid && last_tap) state_next = LOAD_B;
         end
         LOAD_B: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) begin
               if (last_filter) begin
`ifdef LOADER_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = DONE;
`endif
               end else begin
                  state_next = LOAD_W;
               end
            end
         end
         CHECK: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = LOAD_W;
         end
         default: state_next = IDLE;
      endcase
   end

   // Tap, filter and linear weight-address counters. The weight address
   // simply increments on every accepted weight, which yields f*TAPS + t
   // without a multiplier. Stall cycles leave all three counters untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_cnt    <= '0;
         filter_cnt <= '0;
         waddr_cnt  <= '0;
      end else if (load_start) begin
         tap_cnt    <= '0;
         filter_cnt <= '0;
         waddr_cnt  <= '0;
      end else if (accept) begin
         case (state)
            LOAD_W: begin
               waddr_cnt <= waddr_cnt + WADDR_WIDTH'(1);
               tap_cnt   <= last_tap ? '0 : tap_cnt + TAP_WIDTH'(1);
            end
            LOAD_B: begin
               if (!last_filter) filter_cnt <= filter_cnt + BADDR_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // RAM write ports. Each enable is a one-cycle strobe in the cycle after
   // acceptance. Address and data hold their last written value between
   // writes. Reset kills any strobe that is still pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_wren <= 1'b0;
         w_addr <= '0;
         w_data <= '0;
         b_wren <= 1'b0;
         b_addr <= '0;
         b_data <= '0;
      end else begin
         w_wren <= accept && (state == LOAD_W);
         b_wren <= accept && (state == LOAD_B);
         if (accept && (state == LOAD_W)) begin
            w_addr <= waddr_cnt;
            w_data <= s_data;
         end
         if (accept && (state == LOAD_B)) begin
            b_addr <= filter_cnt;
            b_data <= s_data;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] chk_sum;

   // Running modular sum over weights and biases. The trailing byte taken
   // in CHECK is compared against it and is never written to either RAM.
   // chk_err updates on the same edge that moves the FSM into DONE, so it
   // is valid in the same cycle that done rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_sum <= '0;
         chk_err <= 1'b0;
      end else if (load_start) begin
         chk_sum <= '0;
         chk_err <= 1'b0;
      end else if (accept) begin
         if ((state == LOAD_W) || (state == LOAD_B)) begin
            chk_sum <= chk_sum + s_data;
         end else if (state == CHECK) begin
            chk_err <= (chk_sum != s_data);
         end
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_param_loader.sv
// ---------------------------------------------------------------------------
// tb_conv_param_loader
//
// Directed bench for conv_param_loader built with NUM_FILTERS = 2. The
// stream bytes are 0x00..0x13, plus one trailing checksum byte when
// LOADER_CHECKSUM_EN is defined. Inputs change 1 time unit after the
// rising edge. A negedge monitor logs every RAM write.
// ---------------------------------------------------------------------------
module tb_conv_param_loader;

   localparam int NF     = 2;
   localparam int NBYTES = NF * 10;
`ifdef LOADER_CHECKSUM_EN
   localparam int NTOTAL = NBYTES + 1;
`else
   localparam int NTOTAL = NBYTES;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        w_wren;
   logic [14:0] w_addr;
   logic [7:0]  w_data;
   logic        b_wren;
   logic [5:0]  b_addr;
   logic [7:0]  b_data;
   logic        busy;
   logic        done;
   logic        chk_err;

   int vectors = 0;
   int errors  = 0;

   int   w_log_a[$];
   int   w_log_d[$];
   int   b_log_a[$];
   int   b_log_d[$];
   int   spurious_wr = 0;
   logic prev_acc    = 1'b0;

   int   cycles;
   logic done_at_last;

   conv_param_loader #(.NUM_FILTERS(NF)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .w_wren  (w_wren),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .b_wren  (b_wren),
      .b_addr  (b_addr),
      .b_data  (b_data),
      .busy    (busy),
      .done    (done),
      .chk_err (chk_err)
   );

   always #5 clk = ~clk;

   // Mid-cycle write monitor. It logs each write and counts any write
   // strobe that was not preceded by an acceptance in the previous cycle.
   always @(negedge clk) begin
      if (w_wren) begin
         w_log_a.push_back(int'(w_addr));
         w_log_d.push_back(int'(w_data));
      end
      if (b_wren) begin
         b_log_a.push_back(int'(b_addr));
         b_log_d.push_back(int'(b_data));
      end
      if ((w_wren || b_wren) && !prev_acc) spurious_wr++;
      prev_acc = s_valid && s_ready && !rst;
   end

   task automatic clear_logs();
      w_log_a.delete();
      w_log_d.delete();
      b_log_a.delete();
      b_log_d.delete();
      spurious_wr = 0;
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Sends n stream bytes, optionally stalling every other cycle, and
   // optionally pulses start on cycle start_at. It returns the number of
   // cycles used and the done value seen during the final acceptance cycle.
   // It stops in the cycle right after the last acceptance.
   task automatic stream_bytes(input int n, input bit toggle, input logic [7:0] trailer,
                               input int start_at, output int cyc_used, output logic done_last);
      int idx;
      int cyc;
      idx       = 0;
      cyc       = 0;
      done_last = 1'bx;
      while (idx < n && cyc < 400) begin
         @(posedge clk); #1;
         s_valid = !(toggle && (cyc % 2 == 1));
         s_data  = (idx < NBYTES) ? 8'(idx) : trailer;
         start   = (cyc == start_at);
         if (s_valid && s_ready) begin
            idx++;
            done_last = done;
         end
         cyc++;
      end
      @(posedge clk); #1;
      s_valid  = 1'b0;
      start    = 1'b0;
      cyc_used = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (2) @(negedge clk);
      vectors++;
      if ({s_ready, w_wren, w_addr, w_data, b_wren, b_addr, b_data, busy, done, chk_err} !== 43'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h, expected 0",
                  {s_ready, w_wren, w_addr, w_data, b_wren, b_addr, b_data, busy, done, chk_err});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({s_ready, w_wren, w_addr, w_data, b_wren, b_addr, b_data, busy, done, chk_err} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL idle_outputs%0d: got %h, expected 0", i,
                     {s_ready, w_wren, w_addr, w_data, b_wren, b_addr, b_data, busy, done, chk_err});
         end
      end
      do_start();
      vectors++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL start_ready: got s_ready=%b busy=%b, expected 1 1", s_ready, busy);
      end
   endtask

   // Runs directly after test_reset, which leaves the loader in LOAD_W
   task automatic test_continuous();
      clear_logs();
      stream_bytes(NTOTAL, 1'b0, 8'hBE, -1, cycles, done_at_last);
      vectors++;
      if (cycles !== NTOTAL || done_at_last !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cont_timing: got cycles=%0d done_in_last=%b, expected %0d 0",
                  cycles, done_at_last, NTOTAL);
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || chk_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cont_done: got done=%b busy=%b s_ready=%b chk_err=%b, expected 1 0 0 0",
                  done, busy, s_ready, chk_err);
      end
`ifndef LOADER_CHECKSUM_EN
      vectors++;
      if (b_wren !== 1'b1 || b_addr !== 6'd1 || b_data !== 8'h13) begin
         errors++;
         $display("[TB] FAIL cont_last_bias: got wren=%b addr=%0d data=%h, expected 1 1 13",
                  b_wren, b_addr, b_data);
      end
`endif
      repeat (2) @(negedge clk);
      vectors++;
      if (w_log_a.size() !== NF * 9 || b_log_a.size() !== NF || spurious_wr !== 0) begin
         errors++;
         $display("[TB] FAIL cont_counts: got w=%0d b=%0d spurious=%0d, expected %0d %0d 0",
                  w_log_a.size(), b_log_a.size(), spurious_wr, NF * 9, NF);
      end
      foreach (w_log_a[k]) begin
         vectors++;
         if (w_log_a[k] !== k || w_log_d[k] !== (k / 9) * 10 + k % 9) begin
            errors++;
            $display("[TB] FAIL cont_w%0d: got addr=%0d data=%0d, expected %0d %0d",
                     k, w_log_a[k], w_log_d[k], k, (k / 9) * 10 + k % 9);
         end
      end
      foreach (b_log_a[k]) begin
         vectors++;
         if (b_log_a[k] !== k || b_log_d[k] !== k * 10 + 9) begin
            errors++;
            $display("[TB] FAIL cont_b%0d: got addr=%0d data=%0d, expected %0d %0d",
                     k, b_log_a[k], b_log_d[k], k, k * 10 + 9);
         end
      end
   endtask

   task automatic test_restart_from_done();
      vectors++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_held: got %b, expected 1", done);
      end
      do_start();
      vectors++;
      if (done !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_restart: got done=%b s_ready=%b, expected 0 1", done, s_ready);
      end
   endtask

   // Runs directly after test_restart_from_done, which leaves the loader in LOAD_W
   task automatic test_stall();
      clear_logs();
      stream_bytes(NTOTAL, 1'b1, 8'hBE, -1, cycles, done_at_last);
      vectors++;
      if (cycles !== 2 * NTOTAL - 1 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_timing: got cycles=%0d done=%b, expected %0d 1",
                  cycles, done, 2 * NTOTAL - 1);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (w_log_a.size() !== NF * 9 || b_log_a.size() !== NF || spurious_wr !== 0) begin
         errors++;
         $display("[TB] FAIL stall_counts: got w=%0d b=%0d spurious=%0d, expected %0d %0d 0",
                  w_log_a.size(), b_log_a.size(), spurious_wr, NF * 9, NF);
      end
      foreach (w_log_a[k]) begin
         vectors++;
         if (w_log_a[k] !== k || w_log_d[k] !== (k / 9) * 10 + k % 9) begin
            errors++;
            $display("[TB] FAIL stall_w%0d: got addr=%0d data=%0d, expected %0d %0d",
                     k, w_log_a[k], w_log_d[k], k, (k / 9) * 10 + k % 9);
         end
      end
      foreach (b_log_a[k]) begin
         vectors++;
         if (b_log_a[k] !== k || b_log_d[k] !== k * 10 + 9) begin
            errors++;
            $display("[TB] FAIL stall_b%0d: got addr=%0d data=%0d, expected %0d %0d",
                     k, b_log_a[k], b_log_d[k], k, k * 10 + 9);
         end
      end
   endtask

   task automatic test_reset_midload();
      do_start();
      stream_bytes(5, 1'b0, 8'hBE, -1, cycles, done_at_last);
      vectors++;
      if (w_wren !== 1'b1 || w_addr !== 15'd4 || w_data !== 8'h04) begin
         errors++;
         $display("[TB] FAIL midload_pending: got wren=%b addr=%0d data=%h, expected 1 4 04",
                  w_wren, w_addr, w_data);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (w_wren !== 1'b0 || b_wren !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midload_reset: got w_wren=%b b_wren=%b s_ready=%b busy=%b, expected 0 0 0 0",
                  w_wren, b_wren, s_ready, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_logs();
      do_start();
      stream_bytes(NTOTAL, 1'b0, 8'hBE, -1, cycles, done_at_last);
      repeat (2) @(negedge clk);
      vectors++;
      if (w_log_a.size() !== NF * 9 || b_log_a.size() !== NF || spurious_wr !== 0 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reload_counts: got w=%0d b=%0d spurious=%0d done=%b, expected %0d %0d 0 1",
                  w_log_a.size(), b_log_a.size(), spurious_wr, done, NF * 9, NF);
      end
      foreach (w_log_a[k]) begin
         vectors++;
         if (w_log_a[k] !== k || w_log_d[k] !== (k / 9) * 10 + k % 9) begin
            errors++;
            $display("[TB] FAIL reload_w%0d: got addr=%0d data=%0d, expected %0d %0d",
                     k, w_log_a[k], w_log_d[k], k, (k / 9) * 10 + k % 9);
         end
      end
   endtask

   task automatic test_start_during_load();
      do_start();
      clear_logs();
      stream_bytes(NTOTAL, 1'b0, 8'hBE, 5, cycles, done_at_last);
      vectors++;
      if (cycles !== NTOTAL || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_start_timing: got cycles=%0d done=%b, expected %0d 1",
                  cycles, done, NTOTAL);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (w_log_a.size() !== NF * 9 || b_log_a.size() !== NF) begin
         errors++;
         $display("[TB] FAIL busy_start_counts: got w=%0d b=%0d, expected %0d %0d",
                  w_log_a.size(), b_log_a.size(), NF * 9, NF);
      end
      foreach (w_log_a[k]) begin
         vectors++;
         if (w_log_a[k] !== k || w_log_d[k] !== (k / 9) * 10 + k % 9) begin
            errors++;
            $display("[TB] FAIL busy_start_w%0d: got addr=%0d data=%0d, expected %0d %0d",
                     k, w_log_a[k], w_log_d[k], k, (k / 9) * 10 + k % 9);
         end
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      do_start();
      clear_logs();
      stream_bytes(NTOTAL, 1'b0, 8'hBF, -1, cycles, done_at_last);
      vectors++;
      if (chk_err !== 1'b1 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL chk_bad: got chk_err=%b done=%b, expected 1 1", chk_err, done);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (w_log_a.size() !== NF * 9 || b_log_a.size() !== NF) begin
         errors++;
         $display("[TB] FAIL chk_trailer_written: got w=%0d b=%0d, expected %0d %0d",
                  w_log_a.size(), b_log_a.size(), NF * 9, NF);
      end
      do_start();
      vectors++;
      if (chk_err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL chk_clear: got chk_err=%b done=%b, expected 0 0", chk_err, done);
      end
      stream_bytes(NTOTAL, 1'b0, 8'hBE, -1, cycles, done_at_last);
      vectors++;
      if (chk_err !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL chk_good: got chk_err=%b done=%b, expected 0 1", chk_err, done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_continuous();
      test_restart_from_done();
      test_stall();
      test_reset_midload();
      test_start_during_load();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
